// File: rtl/mul_pkg.sv
// Shared definitions for the pipelined Booth multiplier: op encodings and
// elaboration-time helpers that size the carry-save reduction tree.
package mul_pkg;

    typedef enum logic [1:0] {
        MUL_OP_MUL  = 2'b00,
        MUL_OP_MADD = 2'b01,
        MUL_OP_MSUB = 2'b10,
        MUL_OP_ALT  = 2'b11
    } mul_op_e;

    localparam int unsigned CSA_S1_MAX_ROWS = 6;

    function automatic int unsigned pp_count(input int unsigned width);
        return width / 2 + 1;
    endfunction

    // Rows left after a number of 3:2 levels; leftover rows pass straight through.
    function automatic int unsigned csa_rows_after(input int unsigned rows, input int unsigned levels);
        int unsigned n;
        n = rows;
        for (int unsigned i = 0; i < levels; i++) n = 2 * (n / 3) + n % 3;
        return n;
    endfunction

    function automatic int unsigned csa_levels(input int unsigned rows, input int unsigned target);
        int unsigned n;
        int unsigned lv;
        n  = rows;
        lv = 0;
        while (n > target) begin
            n  = 2 * (n / 3) + n % 3;
            lv = lv + 1;
        end
        return lv;
    endfunction

endpackage

// File: rtl/booth_pp_sel.sv
// Radix-4 Booth partial-product selector: picks 0, +-x or +-2x from one
// 3-bit multiplier group and shifts it into its row position.
module booth_pp_sel #(
    parameter int unsigned PW    = 65,
    parameter int unsigned SHIFT = 0
) (
    input  logic [2:0]    grp,
    input  logic [PW-1:0] x_pos,
    input  logic [PW-1:0] x_neg,
    output logic [PW-1:0] pp
);

    logic [PW-1:0] sel;

    always_comb begin
        sel = '0;
        case (grp)
            3'b001, 3'b010: sel = x_pos;
            3'b011:         sel = {x_pos[PW-2:0], 1'b0};
            3'b100:         sel = {x_neg[PW-2:0], 1'b0};
            3'b101, 3'b110: sel = x_neg;
            default:        sel = '0;
        endcase
    end

    assign pp = sel << SHIFT;

endmodule

// File: rtl/booth_mul_pipe.sv
// Three-stage radix-4 Booth / Wallace multiplier with MADD/MSUB, one op per
// cycle under valid/ready; all stages advance together on a single enable.
module booth_mul_pipe
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_sign,
    input  logic [1:0]           in_op,
    input  logic [2*WIDTH-1:0]   in_acc,
    input  logic [TAG_W-1:0]     in_tag,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_result,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int unsigned PW  = 2 * WIDTH + 1;
    localparam int unsigned RW  = 2 * WIDTH;
    localparam int unsigned NPP = pp_count(WIDTH);
    localparam int unsigned NL1 = csa_levels(NPP, CSA_S1_MAX_ROWS);
    localparam int unsigned R1  = csa_rows_after(NPP, NL1);
    localparam int unsigned NL2 = csa_levels(R1, 2);

    function automatic logic [PW-1:0] csa_sum(input logic [PW-1:0] x, input logic [PW-1:0] y,
                                              input logic [PW-1:0] z);
        return x ^ y ^ z;
    endfunction

    function automatic logic [PW-1:0] csa_carry(input logic [PW-1:0] x, input logic [PW-1:0] y,
                                                input logic [PW-1:0] z);
        logic [PW-1:0] m;
        m = (x & y) | (x & z) | (y & z);
        return {m[PW-2:0], 1'b0};
    endfunction

    logic                s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d, s3_valid_q, s3_valid_d;
    logic [PW-1:0]       s1_rows_q [R1];
    logic [PW-1:0]       s1_rows_d [R1];
    mul_op_e             s1_op_q, s1_op_d, s2_op_q, s2_op_d;
    logic [RW-1:0]       s1_acc_q, s1_acc_d, s2_acc_q, s2_acc_d;
    logic [TAG_W-1:0]    s1_tag_q, s1_tag_d, s2_tag_q, s2_tag_d, s3_tag_q, s3_tag_d;
    logic [PW-1:0]       s2_sum_q, s2_sum_d, s2_carry_q, s2_carry_d;
    logic [RW-1:0]       s3_result_q, s3_result_d;
    logic [RW-1:0]       prod;
    logic                en;
    logic                unused_top;

    assign en        = !s3_valid_q || out_ready;
    assign in_ready  = en;
    assign out_valid = s3_valid_q;
    assign out_result = s3_result_q;
    assign out_tag   = s3_tag_q;

    // Stage 1: operand extension, Booth recoding and first compression levels.
    logic [WIDTH:0]   a_ext, b_ext;
    logic [WIDTH+2:0] b_rec;
    logic [PW-1:0]    x_pos, x_neg;
    logic [PW-1:0]    s1_lvl [NL1+1][NPP];

    assign a_ext = {in_sign & in_a[WIDTH-1], in_a};
    assign b_ext = {in_sign & in_b[WIDTH-1], in_b};
    assign b_rec = {b_ext[WIDTH], b_ext, 1'b0};
    assign x_pos = {{WIDTH{a_ext[WIDTH]}}, a_ext};
    assign x_neg = ~x_pos + {{(PW-1){1'b0}}, 1'b1};

    for (genvar i = 0; i < NPP; i++) begin : g_pp
        booth_pp_sel #(.PW(PW), .SHIFT(2 * i)) u_sel (
            .grp   (b_rec[2*i+2:2*i]),
            .x_pos (x_pos),
            .x_neg (x_neg),
            .pp    (s1_lvl[0][i])
        );
    end

    for (genvar l = 0; l < NL1; l++) begin : g_s1
        localparam int unsigned NIN  = csa_rows_after(NPP, l);
        localparam int unsigned NG   = NIN / 3;
        localparam int unsigned NOUT = csa_rows_after(NPP, l + 1);
        for (genvar g = 0; g < NG; g++) begin : g_csa
            assign s1_lvl[l+1][2*g]   = csa_sum(s1_lvl[l][3*g], s1_lvl[l][3*g+1], s1_lvl[l][3*g+2]);
            assign s1_lvl[l+1][2*g+1] = csa_carry(s1_lvl[l][3*g], s1_lvl[l][3*g+1], s1_lvl[l][3*g+2]);
        end
        for (genvar j = 0; j < NIN - 3 * NG; j++) begin : g_pass
            assign s1_lvl[l+1][2*NG+j] = s1_lvl[l][3*NG+j];
        end
        for (genvar j = NOUT; j < NPP; j++) begin : g_zero
            assign s1_lvl[l+1][j] = '0;
        end
    end

    // Stage 2: reduce the registered rows to a single sum/carry pair.
    logic [PW-1:0] s2_lvl [NL2+1][R1];

    for (genvar r = 0; r < R1; r++) begin : g_s2_in
        assign s2_lvl[0][r] = s1_rows_q[r];
    end

    for (genvar l = 0; l < NL2; l++) begin : g_s2
        localparam int unsigned NIN  = csa_rows_after(R1, l);
        localparam int unsigned NG   = NIN / 3;
        localparam int unsigned NOUT = csa_rows_after(R1, l + 1);
        for (genvar g = 0; g < NG; g++) begin : g_csa
            assign s2_lvl[l+1][2*g]   = csa_sum(s2_lvl[l][3*g], s2_lvl[l][3*g+1], s2_lvl[l][3*g+2]);
            assign s2_lvl[l+1][2*g+1] = csa_carry(s2_lvl[l][3*g], s2_lvl[l][3*g+1], s2_lvl[l][3*g+2]);
        end
        for (genvar j = 0; j < NIN - 3 * NG; j++) begin : g_pass
            assign s2_lvl[l+1][2*NG+j] = s2_lvl[l][3*NG+j];
        end
        for (genvar j = NOUT; j < R1; j++) begin : g_zero
            assign s2_lvl[l+1][j] = '0;
        end
    end

    // The extra product bit only matters modulo 2^PW and never reaches the result.
    assign unused_top = s2_sum_q[RW] ^ s2_carry_q[RW];
    assign prod = s2_sum_q[RW-1:0] + s2_carry_q[RW-1:0];

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s2_valid_d  = s2_valid_q;
        s3_valid_d  = s3_valid_q;
        s1_rows_d   = s1_rows_q;
        s1_op_d     = s1_op_q;
        s1_acc_d    = s1_acc_q;
        s1_tag_d    = s1_tag_q;
        s2_op_d     = s2_op_q;
        s2_acc_d    = s2_acc_q;
        s2_tag_d    = s2_tag_q;
        s2_sum_d    = s2_sum_q;
        s2_carry_d  = s2_carry_q;
        s3_result_d = s3_result_q;
        s3_tag_d    = s3_tag_q;

        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
            s3_valid_d = 1'b0;
        end else if (en) begin
            s1_valid_d = in_valid;
            s2_valid_d = s1_valid_q;
            s3_valid_d = s2_valid_q;
        end

        if (en) begin
            for (int unsigned r = 0; r < R1; r++) s1_rows_d[r] = s1_lvl[NL1][r];
            s1_op_d    = mul_op_e'(in_op);
            s1_acc_d   = in_acc;
            s1_tag_d   = in_tag;
            s2_op_d    = s1_op_q;
            s2_acc_d   = s1_acc_q;
            s2_tag_d   = s1_tag_q;
            s2_sum_d   = s2_lvl[NL2][0];
            s2_carry_d = s2_lvl[NL2][1];
            s3_tag_d   = s2_tag_q;
            case (s2_op_q)
                MUL_OP_MADD: s3_result_d = s2_acc_q + prod;
                MUL_OP_MSUB: s3_result_d = s2_acc_q + ~prod + RW'(1);
                default:     s3_result_d = prod;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s3_valid_q  <= 1'b0;
            s3_result_q <= '0;
            s3_tag_q    <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            s3_valid_q  <= s3_valid_d;
            s3_result_q <= s3_result_d;
            s3_tag_q    <= s3_tag_d;
        end
        s1_rows_q  <= s1_rows_d;
        s1_op_q    <= s1_op_d;
        s1_acc_q   <= s1_acc_d;
        s1_tag_q   <= s1_tag_d;
        s2_op_q    <= s2_op_d;
        s2_acc_q   <= s2_acc_d;
        s2_tag_q   <= s2_tag_d;
        s2_sum_q   <= s2_sum_d;
        s2_carry_q <= s2_carry_d;
    end

endmodule

// File: doc/booth_mul_pipe.md
Name: booth_mul_pipe

Overview:
Parametrised, pipelined radix-4 Booth / Wallace-tree multiplier with multiply-accumulate support. It is the sequential successor of the single-cycle combinational 32x32 multiplier. It sits in the EX/MEM path of the CPU and feeds the HI/LO unit. It accepts one operation per cycle under a valid/ready handshake and supports MUL, MADD and MSUB in signed or unsigned mode, with flush for exceptions.

Parameters:
WIDTH, 32, operand width; must be even, legal range 8..64; product width is 2*WIDTH
TAG_W, 4, width of the opaque tag carried alongside each operation

Ports:
clk  in  1  clock; all state updates on the rising edge
resetn  in  1  synchronous, active-low reset
in_valid  in  1  operation presented
in_ready  out  1  block can accept this cycle
in_a  in  WIDTH  multiplicand
in_b  in  WIDTH  multiplier (Booth-recoded)
in_sign  in  1  1 = signed operands, 0 = unsigned
in_op  in  2  00 MUL, 01 MADD, 10 MSUB, 11 treated as MUL
in_acc  in  2*WIDTH  accumulator operand (current HI:LO); ignored for MUL
in_tag  in  TAG_W  passthrough tag
flush  in  1  kill all in-flight operations
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_result  out  2*WIDTH  result
out_tag  out  TAG_W  tag of the result

Behaviour:
- Reset: synchronous, on clk when resetn=0. Clears all stage valid bits. out_valid=0, out_result=0, out_tag=0. Internal data registers need not be cleared. Reset mid-operation discards every in-flight op.
- Pipeline: three stages, advancing together under a single enable, en = !out_valid || out_ready.
  - S1 (registered at end of cycle N): sign/zero-extend operands to WIDTH+1 bits; WIDTH/2+1 Booth partial products, each 2*WIDTH+1 bits, with two's-complement negation; first carry-save compression down to at most 6 rows.
  - S2: remaining 3:2 compression down to sum and carry rows.
  - S3: align the accumulator and add. MUL gives S+C. MADD gives acc+S+C. MSUB gives acc+~(S+C)+1. The result is truncated to 2*WIDTH bits, with wrap-around and no saturation.
- Latency and throughput: an op accepted in cycle N has out_valid=1 in cycle N+3 when no stall occurs. Throughput is one op per cycle.
- Handshake:
  - in_ready = en. An op is accepted when in_valid && in_ready && !flush.
  - An output transfer occurs when out_valid && out_ready.
  - While out_valid && !out_ready, all stages hold and out_result/out_tag stay stable.
  - There is no bubble collapse: stages hold as a block.
- Empty stages: bubbles propagate as valid=0. out_result/out_tag are don't-care while out_valid=0, but must not change while a stalled result is held.
- Flush: takes priority. In the flush cycle all stage valid bits clear, including the output stage, and any input presented in the same cycle is dropped. The next accepted op behaves normally.
- Flush vs stall: flush clears even a stalled output; no transfer occurs in that cycle.
- Ordering: results leave in acceptance order; the tag is carried unchanged.
- Arithmetic correctness: out_result equals the exact 2*WIDTH-bit product (signed or unsigned per in_sign), combined with in_acc modulo 2^(2*WIDTH).
- Unsigned-mode requirement: with in_sign=0 and in_b MSB=1, the extra top Booth digit must yield the correct result.
- in_op=11: behaves exactly as MUL.

Decomposition:
- Shared package mul_pkg holds the op encodings MUL_OP_MUL, MUL_OP_MADD and MUL_OP_MSUB, plus a function returning the partial-product count for a given WIDTH.
- One sub-module, booth_pp_sel, selects one partial product from a 3-bit Booth group, x and -x (0, ±x, ±2x, shifted).
- The compression tree is generated with generate loops in the parent.

Test Plan:
- Unsigned: a=0xFFFFFFFF, b=0xFFFFFFFF, op MUL, accepted in cycle 10 -> out_valid in cycle 13 with out_result=0xFFFFFFFE00000001.
- Signed: a=0xFFFFFFFF, b=0x00000002 -> 0xFFFFFFFFFFFFFFFE. Signed a=0x80000000, b=0x80000000 -> 0x4000000000000000. Unsigned same operands -> 0x4000000000000000.
- MAC: MADD signed acc=0x0000000100000000, a=3, b=5 -> 0x000000010000000F. MSUB acc=0, a=1, b=1 -> 0xFFFFFFFFFFFFFFFF. MADD unsigned acc=0xFFFFFFFFFFFFFFFF, a=1, b=1 -> 0 (wrap).
- Backpressure: four back-to-back ops tagged 0..3 with out_ready=0 for the two cycles after the first result -> in_ready=0 during those cycles, tag-0 result held stable, all four delivered in order 0..3 with no loss or duplication.
- Flush: two ops in flight plus in_valid=1 with flush=1 in the same cycle -> no out_valid for any of them; an op accepted in the next cycle emerges exactly 3 cycles later.
- Reset and width: resetn=0 with three ops in flight -> next cycle out_valid=0, out_result=0, out_tag=0. A WIDTH=16 instance run with 10k random ops, all modes, random stalls -> every result matches the behavioural model.
